// File: rtl/spi_mem_arbiter_if.sv
// Signal bundle between spi_mem_arbiter, the SPI slave, the local host and the RAM port.
// Latency: none, wires only.
// Backpressure: carried by host_req/host_gnt and by the one-entry SPI pending slot.
interface spi_mem_arbiter_if #(parameter int ADDR_SIZE = 8);
   logic [9:0]           rx_data;
   logic                 rx_valid;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 host_req;
   logic                 host_we;
   logic [ADDR_SIZE-1:0] host_addr;
   logic [7:0]           host_wdata;
   logic                 host_gnt;
   logic [7:0]           host_rdata;
   logic                 host_rvalid;
   logic                 mem_en;
   logic                 mem_we;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [7:0]           mem_din;
   logic [7:0]           mem_dout;
   logic                 spi_ovf;

   modport slave (
      input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, mem_dout,
      output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
             mem_en, mem_we, mem_addr, mem_din, spi_ovf
   );

   modport master (
      output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, mem_dout,
      input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid,
             mem_en, mem_we, mem_addr, mem_din, spi_ovf
   );
endinterface

// File: rtl/spi_mem_arbiter.sv
// SPI command decoder sharing one single-port RAM with a host requester (round-robin).
// Latency: writes issue the cycle after the rx_valid edge uncontested; reads return 2 cycles after issue.
// Backpressure: host holds req until host_gnt; SPI has one pending slot, extra commands set spi_ovf.
module spi_mem_arbiter #(
   parameter int ADDR_SIZE = 8
) (
   input logic clk,
   input logic rst_n,
   spi_mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {ARB, RD_SPI, RD_HOST} state_t;

   localparam logic GNT_SPI  = 1'b0;
   localparam logic GNT_HOST = 1'b1;

   state_t               state, state_nxt;
   logic                 rx_valid_q;
   logic                 accept;
   logic [1:0]           op;
   logic [7:0]           payload;
   logic [ADDR_SIZE-1:0] wr_addr, rd_addr, pend_addr;
   logic [7:0]           pend_data;
   logic                 spi_pend, pend_we;
   logic                 last_grant;
   logic                 gnt_spi, gnt_host;
   logic                 spi_rd_busy, ovf_hit;

   assign accept  = bus.rx_valid & ~rx_valid_q;
   assign op      = bus.rx_data[9:8];
   assign payload = bus.rx_data[7:0];

   // A read counts as in flight from the cycle it is granted until its capture cycle.
   assign spi_rd_busy = (state == RD_SPI) | (gnt_spi & ~pend_we);
   // The grant sees the old pending slot; a same-cycle command is checked against what remains.
   assign ovf_hit     = accept & op[0] & ((spi_pend & ~gnt_spi) | spi_rd_busy);

   assign bus.host_gnt = gnt_host;

   // Arbitrate in ARB, drive the RAM port for the winner, and pick the next state.
   always_comb begin
      gnt_spi      = 1'b0;
      gnt_host     = 1'b0;
      state_nxt    = state;
      bus.mem_en   = 1'b0;
      bus.mem_we   = 1'b0;
      bus.mem_addr = '0;
      bus.mem_din  = '0;
      if (state == ARB) begin
         if (spi_pend && (!bus.host_req || last_grant == GNT_HOST)) begin
            gnt_spi = 1'b1;
         end else if (bus.host_req) begin
            gnt_host = 1'b1;
         end
      end else begin
         state_nxt = ARB;
      end
      if (gnt_spi) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = pend_we;
         bus.mem_addr = pend_addr;
         bus.mem_din  = pend_we ? pend_data : 8'h00;
         if (!pend_we) state_nxt = RD_SPI;
      end else if (gnt_host) begin
         bus.mem_en   = 1'b1;
         bus.mem_we   = bus.host_we;
         bus.mem_addr = bus.host_addr;
         bus.mem_din  = bus.host_we ? bus.host_wdata : 8'h00;
         if (!bus.host_we) state_nxt = RD_HOST;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ARB;
      else        state <= state_nxt;
   end

   // Registered rx_valid so that a held level is consumed only once.
   always_ff @(posedge clk) begin
      if (!rst_n) rx_valid_q <= 1'b0;
      else        rx_valid_q <= bus.rx_valid;
   end

   // Command decode: address registers, the one-entry pending slot and the sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_addr     <= '0;
         rd_addr     <= '0;
         pend_addr   <= '0;
         pend_data   <= 8'h00;
         pend_we     <= 1'b0;
         spi_pend    <= 1'b0;
         bus.spi_ovf <= 1'b0;
      end else begin
         if (gnt_spi) spi_pend <= 1'b0;
         if (ovf_hit) bus.spi_ovf <= 1'b1;
         if (accept) begin
            case (op)
               2'b00:   wr_addr <= payload[ADDR_SIZE-1:0];
               2'b10:   rd_addr <= payload[ADDR_SIZE-1:0];
               default: begin
                  if (!ovf_hit) begin
                     spi_pend  <= 1'b1;
                     pend_we   <= ~op[1];
                     pend_addr <= op[1] ? rd_addr : wr_addr;
                     pend_data <= payload;
                  end
               end
            endcase
         end
      end
   end

   // Round-robin memory: remember who was granted last.
   always_ff @(posedge clk) begin
      if (!rst_n)        last_grant <= GNT_HOST;
      else if (gnt_spi)  last_grant <= GNT_SPI;
      else if (gnt_host) last_grant <= GNT_HOST;
   end

   // Read return: capture RAM data for whichever side issued the read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.tx_data     <= 8'h00;
         bus.tx_valid    <= 1'b0;
         bus.host_rdata  <= 8'h00;
         bus.host_rvalid <= 1'b0;
      end else begin
         bus.host_rvalid <= 1'b0;
         if (accept) bus.tx_valid <= 1'b0;
         if (state == RD_SPI) begin
            bus.tx_data  <= bus.mem_dout;
            bus.tx_valid <= 1'b1;
         end
         if (state == RD_HOST) begin
            bus.host_rdata  <= bus.mem_dout;
            bus.host_rvalid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: directed scenarios plus randomized concurrent traffic.
// Latency: expectations are cycle-exact in the directed tasks, bounded waits in the random task.
// Backpressure: the bench host holds its request until granted; the SPI side paces itself to avoid overrun.
module tb_spi_mem_arbiter;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_mem_arbiter_if #(.ADDR_SIZE(AW)) bus ();

   spi_mem_arbiter #(.ADDR_SIZE(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural RAM on the arbiter's port, plus a count of writes it has seen.
   logic [7:0] ram [256];
   int         wr_cnt = 0;
   initial for (int i = 0; i < 256; i++) ram[i] = 8'h00;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_din;
            wr_cnt            <= wr_cnt + 1;
         end else begin
            bus.mem_dout <= ram[bus.mem_addr];
         end
      end
   end

   // Reference contents of the address ranges owned by each requester in the random phase.
   bit [7:0] spi_mdl  [bit [7:0]];
   bit [7:0] host_mdl [bit [7:0]];
   bit [7:0] spi_keys [$];
   bit [7:0] host_keys[$];
   bit       rnd_done;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle rx_valid pulse; returns in the cycle after the edge (C+1).
   task automatic spi_send(input logic [9:0] w);
      bus.rx_data  = w;
      bus.rx_valid = 1'b1;
      step();
      bus.rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.rx_data = '0; bus.rx_valid = 1'b0;
      bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.tx_data, bus.tx_valid, bus.host_rdata, bus.host_rvalid, bus.host_gnt, bus.mem_en,
           bus.mem_we, bus.mem_addr, bus.mem_din, bus.spi_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got tx=%h/%b hr=%h/%b gnt=%b en=%b ovf=%b want all 0",
                  bus.tx_data, bus.tx_valid, bus.host_rdata, bus.host_rvalid, bus.host_gnt, bus.mem_en, bus.spi_ovf);
      end
      step();
   endtask

   task automatic test_spi_write_read();
      spi_send(10'h012); step();
      spi_send(10'h1A5);
      @(negedge clk); n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !== {1'b1, 1'b1, 8'h12, 8'hA5}) begin
         n_fail++;
         $display("FAIL spi_write_issue: got en=%b we=%b a=%h d=%h want 1 1 12 a5", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din);
      end
      step();
      spi_send(10'h212); step();
      spi_send(10'h300);
      @(negedge clk); n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h12}) begin
         n_fail++;
         $display("FAIL spi_read_issue: got en=%b we=%b a=%h want 1 0 12", bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      step(); @(negedge clk); n_cmp++;
      if (bus.tx_valid !== 1'b0) begin
         n_fail++; $display("FAIL spi_read_early: got tx_valid=%b want 0 at C+2", bus.tx_valid);
      end
      step(); @(negedge clk); n_cmp++;
      if ({bus.tx_valid, bus.tx_data} !== {1'b1, 8'hA5}) begin
         n_fail++; $display("FAIL spi_read_data: got %b/%h want 1/a5 at C+3", bus.tx_valid, bus.tx_data);
      end
      n_cmp++;
      if (ram[8'h12] !== 8'hA5) begin
         n_fail++; $display("FAIL spi_ram_12: got %h want a5", ram[8'h12]);
      end
      repeat (3) step();
      @(negedge clk); n_cmp++;
      if (bus.tx_valid !== 1'b1) begin
         n_fail++; $display("FAIL tx_valid_hold: got %b want 1", bus.tx_valid);
      end
      spi_send(10'h0FF);
      @(negedge clk); n_cmp++;
      if ({bus.tx_valid, bus.tx_data} !== {1'b0, 8'hA5}) begin
         n_fail++; $display("FAIL tx_valid_clear: got %b/%h want 0/a5", bus.tx_valid, bus.tx_data);
      end
      step();
   endtask

   task automatic test_host_roundtrip();
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h40; bus.host_wdata = 8'h3C;
      @(negedge clk); n_cmp++;
      if ({bus.host_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !== {1'b1, 1'b1, 1'b1, 8'h40, 8'h3C}) begin
         n_fail++;
         $display("FAIL host_write: got gnt=%b en=%b we=%b a=%h d=%h want 1 1 1 40 3c",
                  bus.host_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din);
      end
      step();
      bus.host_we = 1'b0;
      @(negedge clk); n_cmp++;
      if ({bus.host_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 1'b0, 8'h40}) begin
         n_fail++;
         $display("FAIL host_read_issue: got gnt=%b en=%b we=%b a=%h want 1 1 0 40", bus.host_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      step();
      bus.host_req = 1'b0;
      @(negedge clk); n_cmp++;
      if (bus.host_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL host_rvalid_early: got %b want 0 at T+1", bus.host_rvalid);
      end
      step(); @(negedge clk); n_cmp++;
      if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 8'h3C}) begin
         n_fail++; $display("FAIL host_read_data: got %b/%h want 1/3c at T+2", bus.host_rvalid, bus.host_rdata);
      end
      step(); @(negedge clk); n_cmp++;
      if (bus.host_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL host_rvalid_pulse: got %b want 0 at T+3", bus.host_rvalid);
      end
   endtask

   task automatic test_contention();
      // First conflict: host was granted last, so SPI goes first.
      spi_send(10'h005); step();
      spi_send(10'h177);
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h05; bus.host_wdata = 8'h11;
      @(negedge clk); n_cmp++;
      if ({bus.host_gnt, bus.mem_en, bus.mem_addr, bus.mem_din} !== {1'b0, 1'b1, 8'h05, 8'h77}) begin
         n_fail++; $display("FAIL conflict1_spi_first: got gnt=%b en=%b a=%h d=%h want 0 1 05 77",
                            bus.host_gnt, bus.mem_en, bus.mem_addr, bus.mem_din);
      end
      step(); @(negedge clk); n_cmp++;
      if ({bus.host_gnt, bus.mem_addr, bus.mem_din} !== {1'b1, 8'h05, 8'h11}) begin
         n_fail++; $display("FAIL conflict1_host_next: got gnt=%b a=%h d=%h want 1 05 11", bus.host_gnt, bus.mem_addr, bus.mem_din);
      end
      step();
      bus.host_req = 1'b0;
      @(negedge clk); n_cmp++;
      if (ram[8'h05] !== 8'h11) begin
         n_fail++; $display("FAIL conflict1_ram: got %h want 11", ram[8'h05]);
      end
      // An uncontested SPI write makes SPI the last grantee; the repeated conflict then favours the host.
      spi_send(10'h006); step();
      spi_send(10'h122); step();
      spi_send(10'h133);
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h06; bus.host_wdata = 8'h44;
      @(negedge clk); n_cmp++;
      if ({bus.host_gnt, bus.mem_addr, bus.mem_din} !== {1'b1, 8'h06, 8'h44}) begin
         n_fail++; $display("FAIL conflict2_host_first: got gnt=%b a=%h d=%h want 1 06 44", bus.host_gnt, bus.mem_addr, bus.mem_din);
      end
      step();
      bus.host_req = 1'b0;
      @(negedge clk); n_cmp++;
      if ({bus.host_gnt, bus.mem_en, bus.mem_addr, bus.mem_din} !== {1'b0, 1'b1, 8'h06, 8'h33}) begin
         n_fail++; $display("FAIL conflict2_spi_next: got gnt=%b en=%b a=%h d=%h want 0 1 06 33",
                            bus.host_gnt, bus.mem_en, bus.mem_addr, bus.mem_din);
      end
      step(); @(negedge clk); n_cmp++;
      if (ram[8'h06] !== 8'h33) begin
         n_fail++; $display("FAIL conflict2_ram: got %h want 33", ram[8'h06]);
      end
   endtask

   task automatic test_level_rx_valid();
      int cnt0;
      cnt0 = wr_cnt;
      bus.rx_data  = 10'h15A;
      bus.rx_valid = 1'b1;
      repeat (20) step();
      bus.rx_valid = 1'b0;
      repeat (3) step();
      n_cmp++;
      if (wr_cnt - cnt0 !== 1) begin
         n_fail++; $display("FAIL level_rx_writes: got %0d want 1", wr_cnt - cnt0);
      end
      n_cmp++;
      if (ram[8'h06] !== 8'h5A) begin
         n_fail++; $display("FAIL level_rx_ram: got %h want 5a", ram[8'h06]);
      end
   endtask

   task automatic test_overrun();
      int cnt0;
      spi_send(10'h020); step();
      n_cmp++;
      if (bus.spi_ovf !== 1'b0) begin
         n_fail++; $display("FAIL ovf_before: got %b want 0", bus.spi_ovf);
      end
      cnt0 = wr_cnt;
      spi_send(10'h1AA);
      // SPI was granted last, so the host read wins and holds the port for two cycles.
      bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h40;
      @(negedge clk); n_cmp++;
      if ({bus.host_gnt, bus.mem_we} !== {1'b1, 1'b0}) begin
         n_fail++; $display("FAIL ovf_host_read_gnt: got gnt=%b we=%b want 1 0", bus.host_gnt, bus.mem_we);
      end
      step();
      bus.host_req = 1'b0;
      bus.rx_data = 10'h1BB; bus.rx_valid = 1'b1;
      @(negedge clk); n_cmp++;
      if (bus.mem_en !== 1'b0) begin
         n_fail++; $display("FAIL ovf_busy_idle: got en=%b want 0", bus.mem_en);
      end
      step();
      bus.rx_valid = 1'b0;
      @(negedge clk); n_cmp++;
      if ({bus.spi_ovf, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din} !== {1'b1, 1'b1, 1'b1, 8'h20, 8'hAA}) begin
         n_fail++; $display("FAIL ovf_first_write: got ovf=%b en=%b we=%b a=%h d=%h want 1 1 1 20 aa",
                            bus.spi_ovf, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_din);
      end
      n_cmp++;
      if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 8'h3C}) begin
         n_fail++; $display("FAIL ovf_host_rdata: got %b/%h want 1/3c", bus.host_rvalid, bus.host_rdata);
      end
      repeat (4) step();
      n_cmp++;
      if (wr_cnt - cnt0 !== 1 || ram[8'h20] !== 8'hAA || bus.spi_ovf !== 1'b1) begin
         n_fail++; $display("FAIL ovf_dropped: got writes=%0d ram=%h ovf=%b want 1 aa 1", wr_cnt - cnt0, ram[8'h20], bus.spi_ovf);
      end
   endtask

   task automatic test_reset_mid_read();
      bit tv_seen;
      spi_send(10'h230); step();
      spi_send(10'h300);
      @(negedge clk); n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h30}) begin
         n_fail++; $display("FAIL rst_read_issue: got en=%b we=%b a=%h want 1 0 30", bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk); n_cmp++;
      if ({bus.tx_data, bus.tx_valid, bus.host_rdata, bus.host_rvalid, bus.host_gnt, bus.mem_en,
           bus.mem_we, bus.mem_addr, bus.mem_din, bus.spi_ovf} !== '0) begin
         n_fail++; $display("FAIL rst_mid_outputs: got tx=%h/%b hr=%h/%b en=%b ovf=%b want all 0",
                            bus.tx_data, bus.tx_valid, bus.host_rdata, bus.host_rvalid, bus.mem_en, bus.spi_ovf);
      end
      tv_seen = 1'b0;
      repeat (6) begin
         step(); @(negedge clk);
         if (bus.tx_valid || bus.host_rvalid) tv_seen = 1'b1;
      end
      n_cmp++;
      if (tv_seen !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_no_return: got a read return want none");
      end
   endtask

   // SPI agent: owns addresses 0x00-0x7f, paces commands so it never overruns.
   task automatic spi_agent();
      for (int k = 0; k < 40; k++) begin
         bit [7:0] a, d;
         bit       got;
         if (spi_keys.size() == 0 || $urandom_range(0, 1) == 1) begin
            a = {1'b0, 7'($urandom)};
            d = 8'($urandom);
            spi_send({2'b00, a}); step();
            spi_send({2'b01, d});
            repeat (4) step();
            spi_mdl[a] = d;
            spi_keys.push_back(a);
         end else begin
            a = spi_keys[$urandom_range(0, spi_keys.size() - 1)];
            spi_send({2'b10, a}); step();
            spi_send(10'h300);
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
               @(negedge clk);
               if (bus.tx_valid) got = 1'b1;
               else step();
            end
            n_cmp++;
            if (!got || bus.tx_data !== spi_mdl[a]) begin
               n_fail++; $display("FAIL rnd_spi_read a=%h: got %b/%h want 1/%h", a, got, bus.tx_data, spi_mdl[a]);
            end
            step();
         end
      end
   endtask

   // Host agent: owns addresses 0x80-0xff, holds each request until granted.
   task automatic host_agent();
      for (int k = 0; k < 40; k++) begin
         bit [7:0] a, d;
         bit       we, got;
         repeat ($urandom_range(0, 3)) step();
         we = (host_keys.size() == 0) || ($urandom_range(0, 1) == 1);
         a  = we ? {1'b1, 7'($urandom)} : host_keys[$urandom_range(0, host_keys.size() - 1)];
         d  = 8'($urandom);
         bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = bus.host_gnt;
            step();
         end
         bus.host_req = 1'b0;
         n_cmp++;
         if (!got) begin
            n_fail++; $display("FAIL rnd_host_gnt a=%h: got no grant want grant within 10 cycles", a);
         end
         if (we) begin
            host_mdl[a] = d;
            host_keys.push_back(a);
         end else begin
            got = 1'b0;
            for (int i = 0; i < 4 && !got; i++) begin
               @(negedge clk);
               got = bus.host_rvalid;
               if (!got) step();
            end
            n_cmp++;
            if (!got || bus.host_rdata !== host_mdl[a]) begin
               n_fail++; $display("FAIL rnd_host_read a=%h: got %b/%h want 1/%h", a, got, bus.host_rdata, host_mdl[a]);
            end
            step();
         end
      end
   endtask

   task automatic test_random();
      rnd_done = 1'b0;
      fork
         begin
            fork
               spi_agent();
               host_agent();
            join
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               if (!bus.mem_en) begin
                  n_cmp++;
                  if ({bus.host_gnt, bus.mem_we, bus.mem_addr, bus.mem_din} !== '0) begin
                     n_fail++; $display("FAIL rnd_idle_port: got gnt=%b we=%b a=%h d=%h want 0",
                                        bus.host_gnt, bus.mem_we, bus.mem_addr, bus.mem_din);
                  end
               end
            end
         end
      join
      repeat (4) step();
      foreach (spi_mdl[a]) begin
         n_cmp++;
         if (ram[a] !== spi_mdl[a]) begin
            n_fail++; $display("FAIL rnd_spi_ram a=%h: got %h want %h", a, ram[a], spi_mdl[a]);
         end
      end
      foreach (host_mdl[a]) begin
         n_cmp++;
         if (ram[a] !== host_mdl[a]) begin
            n_fail++; $display("FAIL rnd_host_ram a=%h: got %h want %h", a, ram[a], host_mdl[a]);
         end
      end
      n_cmp++;
      if (bus.spi_ovf !== 1'b0) begin
         n_fail++; $display("FAIL rnd_no_ovf: got %b want 0", bus.spi_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_spi_write_read();
      test_host_roundtrip();
      test_contention();
      test_level_rx_valid();
      test_overrun();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish before time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
